// File: rtl/dmem_arbiter_if.sv
// Bus between the two data-memory requesters, the arbiter and data_memory.
// The arbiter attaches through the slave modport; whatever plays the
// requesters and the memory attaches through the master modport.
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_ack;
  logic                  m0_rvalid;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_ack;
  logic                  m1_rvalid;

  logic [DATA_WIDTH-1:0] rdata;

  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_reg;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_ack, m0_rvalid,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_ack, m1_rvalid,
    output rdata,
    output mem_write, mem_reg, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_ack, m0_rvalid,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_ack, m1_rvalid,
    input  rdata,
    input  mem_write, mem_reg, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data_memory between the CPU
// data port (m0) and the loader/debug master (m1). An owner keeps the memory
// while it requests, but hands it over after MAX_BURST accesses if the other
// master is waiting. Acks and the memory drive are combinational from the
// owner state; read data comes back registered one cycle after the ack.
// ADDR_WIDTH/DATA_WIDTH must match the parameters of the connected interface.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = MAX_BURST[CNT_WIDTH-1:0];
  localparam logic [CNT_WIDTH:0]   BURST_LIM = MAX_BURST[CNT_WIDTH:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                state;
  logic                  last;
  logic [CNT_WIDTH-1:0]  burst_cnt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  m0_rvalid_q;
  logic                  m1_rvalid_q;

  logic                  ack0;
  logic                  ack1;
  logic                  mem_write_c;
  logic [ADDR_WIDTH-1:0] mem_reg_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [CNT_WIDTH:0]    burst_sum;
  logic                  burst_done;
  logic [CNT_WIDTH-1:0]  burst_inc;

  // Route the owner's request to the memory; reset blocks every ack and write
  always_comb begin
    ack0        = 1'b0;
    ack1        = 1'b0;
    mem_write_c = 1'b0;
    mem_reg_c   = '0;
    mem_wdata_c = '0;
    if (!reset) begin
      case (state)
        OWN0: begin
          ack0        = bus.m0_req;
          mem_write_c = bus.m0_req & bus.m0_we;
          mem_reg_c   = bus.m0_addr;
          mem_wdata_c = bus.m0_wdata;
        end
        OWN1: begin
          ack1        = bus.m1_req;
          mem_write_c = bus.m1_req & bus.m1_we;
          mem_reg_c   = bus.m1_addr;
          mem_wdata_c = bus.m1_wdata;
        end
        default: begin
          mem_write_c = 1'b0;
        end
      endcase
    end
  end

  // Tenure accounting: the access acked this cycle counts toward the limit
  always_comb begin
    burst_sum  = {1'b0, burst_cnt} + {{CNT_WIDTH{1'b0}}, (ack0 | ack1)};
    burst_done = (burst_sum >= BURST_LIM);
    burst_inc  = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_WIDTH'(1);
  end

  // Ownership FSM, burst counter and registered read return
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      burst_cnt   <= '0;
      rdata_q     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      if (ack0 && !bus.m0_we) begin
        rdata_q     <= bus.mem_read_data;
        m0_rvalid_q <= 1'b1;
      end
      if (ack1 && !bus.m1_we) begin
        rdata_q     <= bus.mem_read_data;
        m1_rvalid_q <= 1'b1;
      end
      if (ack0 || ack1) begin
        burst_cnt <= burst_inc;
      end

      case (state)
        IDLE: begin
          if (bus.m0_req && bus.m1_req) begin
            state <= last ? OWN0 : OWN1;
          end else if (bus.m0_req) begin
            state <= OWN0;
          end else if (bus.m1_req) begin
            state <= OWN1;
          end
        end
        OWN0: begin
          if (bus.m1_req && (!bus.m0_req || burst_done)) begin
            state     <= OWN1;
            last      <= 1'b0;
            burst_cnt <= '0;
          end else if (!bus.m0_req) begin
            state     <= IDLE;
            last      <= 1'b0;
            burst_cnt <= '0;
          end
        end
        OWN1: begin
          if (bus.m0_req && (!bus.m1_req || burst_done)) begin
            state     <= OWN0;
            last      <= 1'b1;
            burst_cnt <= '0;
          end else if (!bus.m1_req) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.m0_ack         = ack0;
  assign bus.m1_ack         = ack1;
  assign bus.m0_rvalid      = m0_rvalid_q;
  assign bus.m1_rvalid      = m1_rvalid_q;
  assign bus.rdata          = rdata_q;
  assign bus.mem_write      = mem_write_c;
  assign bus.mem_reg        = mem_reg_c;
  assign bus.mem_write_data = mem_wdata_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural data_memory, a per-cycle vector
// table for acks and memory writes, and read-data scoreboards per master.
module tb_dmem_arbiter;

  typedef struct {
    string       name;
    logic        rst;
    logic        r0;
    logic        w0;
    logic [5:0]  a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [5:0]  a1;
    logic [31:0] d1;
    logic        e_ack0;
    logic        e_ack1;
    logic        e_mw;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        mon_en;
  int          n_cmp;
  int          n_fail;
  int          mw_cycles;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  vec_t        vecs [$];

  dmem_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  dmem_arbiter #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .MAX_BURST (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural data_memory: combinational read, write on the rising edge
  assign bus.mem_read_data = mem[bus.mem_reg];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_reg] <= bus.mem_write_data;
  end

  function automatic void cmp1(string n, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", n, act, exp);
    end
  endfunction

  function automatic void cmp32(string n, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", n, act, exp);
    end
  endfunction

  function automatic vec_t mk(string n, int rst, int r0, int w0, int a0, int d0,
                              int r1, int w1, int a1, int d1, int e0, int e1, int emw);
    vec_t t;
    t.name   = n;
    t.rst    = rst[0];
    t.r0     = r0[0];
    t.w0     = w0[0];
    t.a0     = a0[5:0];
    t.d0     = d0;
    t.r1     = r1[0];
    t.w1     = w1[0];
    t.a1     = a1[5:0];
    t.d1     = d1;
    t.e_ack0 = e0[0];
    t.e_ack1 = e1[0];
    t.e_mw   = emw[0];
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    reset        = t.rst;
    bus.m0_req   = t.r0;
    bus.m0_we    = t.w0;
    bus.m0_addr  = t.a0;
    bus.m0_wdata = t.d0;
    bus.m1_req   = t.r1;
    bus.m1_we    = t.w1;
    bus.m1_addr  = t.a1;
    bus.m1_wdata = t.d1;
  endtask

  task automatic checkOutput(input vec_t t);
    cmp1({t.name, ".m0_ack"},    bus.m0_ack,    t.e_ack0);
    cmp1({t.name, ".m1_ack"},    bus.m1_ack,    t.e_ack1);
    cmp1({t.name, ".mem_write"}, bus.mem_write, t.e_mw);
  endtask

  // Read scoreboard: an acked read must return rvalid and data exactly one cycle later
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (mon_en) begin
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp1("m0_rvalid", bus.m0_rvalid, 1'b1);
        cmp32("m0_rdata", bus.rdata, e);
      end else begin
        cmp1("m0_rvalid_quiet", bus.m0_rvalid, 1'b0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp1("m1_rvalid", bus.m1_rvalid, 1'b1);
        cmp32("m1_rdata", bus.rdata, e);
      end else begin
        cmp1("m1_rvalid_quiet", bus.m1_rvalid, 1'b0);
      end
      if (bus.m0_ack && !bus.m0_we) q0.push_back(ref_mem[bus.m0_addr]);
      if (bus.m0_ack &&  bus.m0_we) ref_mem[bus.m0_addr] = bus.m0_wdata;
      if (bus.m1_ack && !bus.m1_we) q1.push_back(ref_mem[bus.m1_addr]);
      if (bus.m1_ack &&  bus.m1_we) ref_mem[bus.m1_addr] = bus.m1_wdata;
      if (bus.mem_write) mw_cycles++;
    end
  end

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: hand-written reset checks, the vector table, final memory checks
  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    mw_cycles = 0;
    mon_en    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    mem[5]     = 32'h1122_3344;
    ref_mem[5] = 32'h1122_3344;
    applyStimulus(mk("init", 1, 0,0,0,0, 0,0,0,0, 0,0,0));

    vecs.push_back(mk("reset",        1, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("m0_rd5_arb",   0, 1,0, 5,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("m0_rd5_ack",   0, 1,0, 5,0,            0,0, 0,0,            1,0,0));
    vecs.push_back(mk("m0_drop",      0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("idle",         0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("reset2",       1, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("both_arb",     0, 1,0, 1,0,            1,0, 2,0,            0,0,0));
    vecs.push_back(mk("both_m0_1st",  0, 1,0, 1,0,            1,0, 2,0,            1,0,0));
    vecs.push_back(mk("m0_drops",     0, 0,0, 0,0,            1,0, 2,0,            0,0,0));
    vecs.push_back(mk("m1_ack",       0, 0,0, 0,0,            1,0, 2,0,            0,1,0));
    vecs.push_back(mk("m1_drop",      0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("idle2",        0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("burst_arb",    0, 1,0,10,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("burst_a1",     0, 1,0,10,0,            0,0, 0,0,            1,0,0));
    vecs.push_back(mk("burst_a2",     0, 1,0,11,0,            1,1,20,32'hCAFEF00D, 1,0,0));
    vecs.push_back(mk("burst_a3",     0, 1,0,12,0,            1,1,20,32'hCAFEF00D, 1,0,0));
    vecs.push_back(mk("burst_a4",     0, 1,0,13,0,            1,1,20,32'hCAFEF00D, 1,0,0));
    vecs.push_back(mk("burst_switch", 0, 1,0,14,0,            1,1,20,32'hCAFEF00D, 0,1,1));
    vecs.push_back(mk("m1_done",      0, 1,0,14,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("m0_back",      0, 1,0,14,0,            0,0, 0,0,            1,0,0));
    vecs.push_back(mk("m0_release",   0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("wr63_arb",     0, 0,0, 0,0,            1,1,63,32'hDEADBEEF, 0,0,0));
    vecs.push_back(mk("wr63",         0, 0,0, 0,0,            1,1,63,32'hDEADBEEF, 0,1,1));
    vecs.push_back(mk("rd63_arb",     0, 1,0,63,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("rd63",         0, 1,0,63,0,            0,0, 0,0,            1,0,0));
    vecs.push_back(mk("rd63_release", 0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("wr7_arb",      0, 0,0, 0,0,            1,1, 7,32'hA5A5A5A5, 0,0,0));
    vecs.push_back(mk("wr7_reset",    1, 0,0, 0,0,            1,1, 7,32'hA5A5A5A5, 0,0,0));
    vecs.push_back(mk("post_reset",   0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("rd7_arb",      0, 1,0, 7,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("rd7",          0, 1,0, 7,0,            0,0, 0,0,            1,0,0));
    vecs.push_back(mk("drop_idle",    0, 0,0, 0,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("rereq_arb",    0, 1,0, 8,0,            0,0, 0,0,            0,0,0));
    vecs.push_back(mk("rereq_ack",    0, 1,0, 8,0,            0,0, 0,0,            1,0,0));
    vecs.push_back(mk("end",          0, 0,0, 0,0,            0,0, 0,0,            0,0,0));

    // Reset with both masters shouting a write: nothing may reach the memory
    @(posedge clk); #1;
    applyStimulus(mk("rst_busy", 1, 1,1,3,32'h55, 1,1,4,32'h66, 0,0,0));
    @(negedge clk);
    cmp1("rst.mem_write", bus.mem_write, 1'b0);
    cmp1("rst.m0_ack", bus.m0_ack, 1'b0);
    cmp1("rst.m1_ack", bus.m1_ack, 1'b0);
    cmp32("rst.mem_reg", {26'b0, bus.mem_reg}, 32'h0);
    cmp32("rst.mem_write_data", bus.mem_write_data, 32'h0);

    // First cycle out of reset: idle outputs and cleared read path
    @(posedge clk); #1;
    applyStimulus(mk("rst_rel", 0, 0,0,0,0, 0,0,0,0, 0,0,0));
    mon_en = 1'b1;
    @(negedge clk);
    cmp32("rst.rdata", bus.rdata, 32'h0);
    cmp1("rst.mem_write_idle", bus.mem_write, 1'b0);
    cmp32("rst.mem_reg_idle", {26'b0, bus.mem_reg}, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i]);
    end

    // Let the last read return drain, then check memory side effects
    @(posedge clk); #1;
    applyStimulus(mk("drain", 0, 0,0,0,0, 0,0,0,0, 0,0,0));
    @(negedge clk);
    cmp32("mem7_untouched", mem[7], 32'h1000_0007);
    cmp32("mem63_written", mem[63], 32'hDEADBEEF);
    cmp32("mem20_written", mem[20], 32'hCAFEF00D);
    cmp32("mem_write_cycles", mw_cycles, 32'd2);
    cmp32("reads_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
